pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
// - Parametrised, pipelined add/subtract unit for the ALU datapath; next generation of the 8-bit ripple adder.
// - Splits the WIDTH-bit carry chain into STAGES equal chunks and registers the carry between chunks.
// - Adds a per-operation op (add/sub), signed-overflow and zero flags, and valid/ready handshakes on both sides.
// PARAMETERS
// - WIDTH   8  operand/result width in bits; must be >= 2.
// - STAGES  2  number of pipeline stages, 1..WIDTH; WIDTH % STAGES == 0 (elaboration-time check via $error).
// PORTS
// - clk        in   1      single clock; all state updates on the rising edge.
// - rst_n      in   1      asynchronous, active-low reset.
// - in_valid   in   1      an operand set is presented.
// - in_ready   out  1      the unit accepts the operand set this cycle.
// - op         in   1      0 = add (a+b+cin), 1 = subtract (a-b-cin, cin acts as borrow-in).
// - a          in   WIDTH  operand A (unsigned or two's complement).
// - b          in   WIDTH  operand B.
// - cin        in   1      carry-in (add) or borrow-in (sub).
// - out_valid  out  1      sum and flags are valid.
// - out_ready  in   1      the consumer takes the result this cycle.
// - sum        out  WIDTH  result bits.
// - cout       out  1      raw carry out of the MSB; for sub, 1 = no borrow.
// - ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB.
// - zero       out  1      sum == 0.
// BEHAVIOUR
// - Arithmetic: effective B = op ? ~b : b; effective carry-in = op ? ~cin : cin; result = A + effB + effCin.
// - Chunk width C = WIDTH/STAGES. Stage k adds bits [k*C +: C] using the carry registered by stage k-1.
//   Not-yet-added upper operand bits and already-computed lower sum bits travel with the token.
// - Latency: exactly STAGES cycles from an accepted input to out_valid when the pipeline does not stall.
// - Throughput: one operation per cycle while out_ready stays high.
// - Handshake: transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
// - Each stage k holds valid[k]. Stage k loads when valid[k]==0 or stage k+1 accepts (the last stage accepts when out_ready).
//   Bubbles are therefore compressed. in_ready = stage 0 may load.
// - in_ready is combinationally dependent on out_ready; there is no combinational path from in_valid to out_valid.
// - While out_valid=1 and out_ready=0, sum, cout, ovf and zero hold stable and in_ready stays 1 until the pipeline is full.
// - Data registers load only on a stage transfer. Operand and op inputs are ignored when in_valid=0.
// - Reset (async assert, any time, including mid-operation): all valid bits clear and in-flight tokens are discarded.
//   sum=0, cout=0, ovf=0, zero=0, out_valid=0. in_ready=1 from the first cycle after deassertion.
// - Flags are computed in the last stage only. zero covers all WIDTH sum bits.
// - STAGES==1: a single registered WIDTH-bit add with latency 1.
// STRUCTURE
// - Shared include alu_defs.vh: `ALU_OP_ADD=1'b0`, `ALU_OP_SUB=1'b1`; reused by the ALU decoder.
// - One natural sub-module: addsub_chunk (combinational, parameter C).
//   Inputs: a, b_eff, ci. Outputs: s, co, and c_msb_in (carry into the chunk MSB, needed for ovf).
//   Instantiated STAGES times in a generate loop; stage registers live in pipelined_addsub.
// TESTING (WIDTH=8, STAGES=2 unless noted)
// - Reset then op=0 a=8'h0F b=8'h01 cin=0, out_ready=1 -> 2 cycles later sum=8'h10 cout=0 ovf=0 zero=0.
// - Sub: op=1 a=8'h80 b=8'h01 cin=0 -> sum=8'h7F cout=1 ovf=1 zero=0.
//   Then op=1 a=8'h05 b=8'h05 cin=0 -> sum=8'h00 cout=1 zero=1.
// - Carry across chunk boundary and wrap: op=0 a=8'hFF b=8'h00 cin=1 -> sum=8'h00 cout=1 ovf=0 zero=1.
// - Back-pressure: stream 4 ops with out_ready=0 -> 2 tokens held, in_ready=0, sum stable.
//   Release out_ready -> all 4 results in order, none lost or duplicated.
// - Reset mid-flight: assert rst_n=0 with 2 tokens in flight -> out_valid=0 and outputs 0 immediately; no stale result after release.
// - Sweep WIDTH=16 STAGES in {1,4,16}: 10k random ops with random valid/ready -> scoreboard exact match, latency == STAGES when unstalled.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Package: pipelined_addsub_pkg
// Purpose: shared opcode encodings for the add/subtract datapath. The ALU
//          decoder drives the op input of pipelined_addsub with these values.
// Contents:
//   ALU_OP_ADD  op value selecting a + b + cin
//   ALU_OP_SUB  op value selecting a - b - cin (cin acts as borrow-in)
package pipelined_addsub_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

endpackage : pipelined_addsub_pkg

// File: rtl/pipelined_addsub_chunk.sv
// Module: addsub_chunk
// Purpose: combinational C-bit slice of the carry chain. One instance per
//          pipeline stage; the surrounding stage registers live in the top.
// Ports:
//   a        in   C  operand A bits for this chunk
//   b_eff    in   C  operand B bits, already inverted for subtract
//   ci       in   1  carry into the chunk LSB
//   s        out  C  chunk sum
//   co       out  1  carry out of the chunk MSB
//   c_msb_in out  1  carry into the chunk MSB (used for signed overflow)
module addsub_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b_eff,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [C:0] full;

  assign full = {1'b0, a} + {1'b0, b_eff} + {{C{1'b0}}, ci};
  assign s    = full[C-1:0];
  assign co   = full[C];
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out by
  // XOR-ing the operands back out.
  assign c_msb_in = a[C-1] ^ b_eff[C-1] ^ full[C-1];

endmodule : addsub_chunk

// File: rtl/pipelined_addsub.sv
// Module: pipelined_addsub
// Purpose: pipelined add/subtract unit. The WIDTH-bit carry chain is split
//          into STAGES chunks of C = WIDTH/STAGES bits with the carry
//          registered between chunks. Result flags come from the last stage.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (op, a, b, cin)
//   op                   0 = add, 1 = subtract
//   a, b                 WIDTH-bit operands
//   cin                  carry-in (add) / borrow-in (subtract)
//   out_valid/out_ready  output handshake (sum, cout, ovf, zero)
//   sum                  WIDTH-bit result
//   cout                 carry out of the MSB (subtract: 1 = no borrow)
//   ovf                  signed overflow
//   zero                 sum == 0
// Handshake: a transfer happens on a side in any cycle where valid and ready
//   are both high at the rising edge. in_ready depends combinationally on
//   out_ready; out_valid is a register output and never depends on in_valid.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C   = WIDTH / STAGES;
  // Operand registers exist only between stages, so there are STAGES-1 of
  // them; keep at least one slot so the declaration stays legal for STAGES==1.
  localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = (op == ALU_OP_SUB) ? ~b : b;
  assign cin_eff = (op == ALU_OP_SUB) ? ~cin : cin;

  // Per-stage state. Operands not yet added travel shifted down so the next
  // stage always finds its chunk in the low C bits.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic [OPS-1:0][WIDTH-1:0]    a_q;
  logic [OPS-1:0][WIDTH-1:0]    b_q;
  logic                         ovf_q;
  logic                         zero_q;
  logic [STAGES-1:0]            load;

  // Stage k may load when it is empty or its downstream neighbour takes its
  // token this cycle; the output register drains on out_ready.
  always_comb begin
    logic acc;
    acc  = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | ~v_q[k];
      load[k] = acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [C-1:0]     ch_a;
    logic [C-1:0]     ch_b;
    logic             ch_ci;
    logic             up_v;
    logic [WIDTH-1:0] up_s;
    logic [C-1:0]     ch_s;
    logic             ch_co;
    logic             ch_msb;
    logic [WIDTH-1:0] s_next;

    if (k == 0) begin : g_first
      assign ch_a  = a[C-1:0];
      assign ch_b  = b_eff[C-1:0];
      assign ch_ci = cin_eff;
      assign up_v  = in_valid;
      assign up_s  = '0;
    end else begin : g_next
      assign ch_a  = a_q[k-1][C-1:0];
      assign ch_b  = b_q[k-1][C-1:0];
      assign ch_ci = c_q[k-1];
      assign up_v  = v_q[k-1];
      assign up_s  = s_q[k-1];
    end

    addsub_chunk #(.C(C)) u_chunk (
      .a        (ch_a),
      .b_eff    (ch_b),
      .ci       (ch_ci),
      .s        (ch_s),
      .co       (ch_co),
      .c_msb_in (ch_msb)
    );

    // Bits above the chunks added so far are still zero in up_s.
    assign s_next = up_s | (WIDTH'(ch_s) << (k * C));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
      end else if (load[k]) begin
        v_q[k] <= up_v;
        if (up_v) begin
          c_q[k] <= ch_co;
          s_q[k] <= s_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_operands
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;

      if (k == 0) begin : g_src_in
        assign src_a = a;
        assign src_b = b_eff;
      end else begin : g_src_reg
        assign src_a = a_q[k-1];
        assign src_b = b_q[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end else if (load[k] && up_v) begin
          a_q[k] <= src_a >> C;
          b_q[k] <= src_b >> C;
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (load[k] && up_v) begin
          ovf_q  <= ch_msb ^ ch_co;
          zero_q <= (s_next == '0);
        end
      end
    end else begin : g_mid
      // Only the top chunk's MSB carry matters for signed overflow.
      logic msb_carry_unused;
      assign msb_carry_unused = ch_msb;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule : pipelined_addsub
